// File: rtl/bl_count_pkg.sv
// Shared constants and types for the Huffman code-length histogram stage.
package bl_count_pkg;

   localparam int unsigned COUNT_BIT = 5;
   localparam int unsigned MAX_LEN   = 15;
   localparam int unsigned LEN_W     = 4;

   typedef logic [LEN_W-1:0] len_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACCUM,
      ST_DONE
   } state_e;

endpackage

// File: rtl/bl_sat_inc.sv
// Saturating incrementer: holds at all-ones and flags the attempted wrap.
module bl_sat_inc #(
   parameter int unsigned W = 5
) (
   input  logic [W-1:0] val,
   output logic [W-1:0] inc_c,
   output logic         ovf_c
);

   assign ovf_c = &val;
   assign inc_c = ovf_c ? val : val + W'(1);

endmodule

// File: rtl/bl_count.sv
// Code-length histogram: counts symbols per length 1..15 and tracks the max length.
module bl_count #(
   parameter int unsigned COUNT_BIT = 5,
   parameter int unsigned NUM_SYM   = 19
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           len_in,
   input  logic                 len_valid,
   input  logic                 len_last,
   output logic                 len_ready,
   output logic [COUNT_BIT-1:0] count_0,
   output logic [COUNT_BIT-1:0] count_1,
   output logic [COUNT_BIT-1:0] count_2,
   output logic [COUNT_BIT-1:0] count_3,
   output logic [COUNT_BIT-1:0] count_4,
   output logic [COUNT_BIT-1:0] count_5,
   output logic [COUNT_BIT-1:0] count_6,
   output logic [COUNT_BIT-1:0] count_7,
   output logic [COUNT_BIT-1:0] count_8,
   output logic [COUNT_BIT-1:0] count_9,
   output logic [COUNT_BIT-1:0] count_10,
   output logic [COUNT_BIT-1:0] count_11,
   output logic [COUNT_BIT-1:0] count_12,
   output logic [COUNT_BIT-1:0] count_13,
   output logic [COUNT_BIT-1:0] count_14,
   output logic [COUNT_BIT-1:0] count_15,
   output logic [COUNT_BIT-1:0] max,
   output logic                 busy,
   output logic                 sig_end,
   output logic                 err_overflow
);

   import bl_count_pkg::*;

   localparam int unsigned SYM_W = $clog2(NUM_SYM + 1);

   state_e               state_q, state_d;
   logic [COUNT_BIT-1:0] cnt_q [MAX_LEN+1];
   logic [COUNT_BIT-1:0] cnt_d [MAX_LEN+1];
   logic [COUNT_BIT-1:0] inc_c [1:MAX_LEN];
   logic [MAX_LEN:1]     ovf_c;
   len_t                 max_q, max_d;
   logic [SYM_W-1:0]     sym_q, sym_d;
   logic                 err_q, err_d;
   logic                 sig_end_q, sig_end_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic                 xfer_c;
   logic                 clr_c;

   // One saturating incrementer per nonzero length; length 0 is never counted.
   for (genvar i = 1; i <= int'(MAX_LEN); i++) begin : g_inc
      bl_sat_inc #(.W(COUNT_BIT)) u_inc (
         .val   (cnt_q[i]),
         .inc_c (inc_c[i]),
         .ovf_c (ovf_c[i])
      );
   end

   assign xfer_c = ready_q & len_valid;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      sym_d   = sym_q;
      err_d   = err_q;
      clr_c   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_CLEAR;
               clr_c   = 1'b1;
            end
         end
         ST_CLEAR: begin
            state_d = ST_ACCUM;
            clr_c   = 1'b1;
         end
         ST_ACCUM: begin
            if (xfer_c) begin
               sym_d = sym_q + SYM_W'(1);
               if (len_in != '0) begin
                  cnt_d[len_in] = inc_c[len_in];
                  err_d         = err_q | ovf_c[len_in];
                  if (len_in > max_q) max_d = len_in;
               end
               if (len_last || (sym_q == SYM_W'(NUM_SYM - 1))) state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs drop on the edge that accepts start, not one cycle later.
      if (clr_c) begin
         cnt_d = '{default: '0};
         max_d = '0;
         sym_d = '0;
         err_d = 1'b0;
      end

      ready_d   = (state_d == ST_ACCUM);
      busy_d    = (state_d == ST_CLEAR) || (state_d == ST_ACCUM);
      sig_end_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '{default: '0};
         max_q     <= '0;
         sym_q     <= '0;
         err_q     <= 1'b0;
         sig_end_q <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         max_q     <= max_d;
         sym_q     <= sym_d;
         err_q     <= err_d;
         sig_end_q <= sig_end_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign len_ready    = ready_q;
   assign busy         = busy_q;
   assign sig_end      = sig_end_q;
   assign err_overflow = err_q;
   assign max          = COUNT_BIT'(max_q);

   assign count_0  = cnt_q[0];
   assign count_1  = cnt_q[1];
   assign count_2  = cnt_q[2];
   assign count_3  = cnt_q[3];
   assign count_4  = cnt_q[4];
   assign count_5  = cnt_q[5];
   assign count_6  = cnt_q[6];
   assign count_7  = cnt_q[7];
   assign count_8  = cnt_q[8];
   assign count_9  = cnt_q[9];
   assign count_10 = cnt_q[10];
   assign count_11 = cnt_q[11];
   assign count_12 = cnt_q[12];
   assign count_13 = cnt_q[13];
   assign count_14 = cnt_q[14];
   assign count_15 = cnt_q[15];

endmodule

// File: tb/tb_bl_count.sv
// Randomized bench for bl_count: two widths driven in lockstep against a histogram model.
module tb_bl_count;

   localparam int NSYM = 19;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [3:0] len_in = '0;
   logic       len_valid = 1'b0;
   logic       len_last = 1'b0;

   logic       rdy5, busy5, end5, err5;
   logic [4:0] c5 [16];
   logic [4:0] max5;
   logic       rdy3, busy3, end3, err3;
   logic [2:0] c3 [16];
   logic [2:0] max3;

   int n_chk  = 0;
   int n_fail = 0;

   int lens_a [32];
   int last_at;
   int n_acc;

   always #5 clock = ~clock;

   bl_count #(.COUNT_BIT(5), .NUM_SYM(NSYM)) u5 (
      .clock(clock), .reset(reset), .start(start), .len_in(len_in),
      .len_valid(len_valid), .len_last(len_last), .len_ready(rdy5),
      .count_0(c5[0]), .count_1(c5[1]), .count_2(c5[2]), .count_3(c5[3]),
      .count_4(c5[4]), .count_5(c5[5]), .count_6(c5[6]), .count_7(c5[7]),
      .count_8(c5[8]), .count_9(c5[9]), .count_10(c5[10]), .count_11(c5[11]),
      .count_12(c5[12]), .count_13(c5[13]), .count_14(c5[14]), .count_15(c5[15]),
      .max(max5), .busy(busy5), .sig_end(end5), .err_overflow(err5)
   );

   bl_count #(.COUNT_BIT(3), .NUM_SYM(NSYM)) u3 (
      .clock(clock), .reset(reset), .start(start), .len_in(len_in),
      .len_valid(len_valid), .len_last(len_last), .len_ready(rdy3),
      .count_0(c3[0]), .count_1(c3[1]), .count_2(c3[2]), .count_3(c3[3]),
      .count_4(c3[4]), .count_5(c3[5]), .count_6(c3[6]), .count_7(c3[7]),
      .count_8(c3[8]), .count_9(c3[9]), .count_10(c3[10]), .count_11(c3[11]),
      .count_12(c3[12]), .count_13(c3[13]), .count_14(c3[14]), .count_15(c3[15]),
      .max(max3), .busy(busy3), .sig_end(end3), .err_overflow(err3)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sum5();
      int s = 0;
      for (int i = 0; i < 16; i++) s += int'(c5[i]);
      return s;
   endfunction

   function automatic int sum3();
      int s = 0;
      for (int i = 0; i < 16; i++) s += int'(c3[i]);
      return s;
   endfunction

   // Histogram of the accepted lengths, saturated and truncated to each width.
   task automatic compare_all(input string tag);
      int hist [16];
      int mx;
      for (int i = 0; i < 16; i++) hist[i] = 0;
      mx = 0;
      for (int k = 0; k < n_acc; k++) begin
         if (lens_a[k] != 0) hist[lens_a[k]]++;
         if (lens_a[k] > mx) mx = lens_a[k];
      end
      for (int i = 0; i < 16; i++) begin
         check($sformatf("%s_u5_cnt%0d", tag, i), int'(c5[i]), (hist[i] > 31) ? 31 : hist[i]);
         check($sformatf("%s_u3_cnt%0d", tag, i), int'(c3[i]), (hist[i] > 7) ? 7 : hist[i]);
      end
      check({tag, "_u5_max"}, int'(max5), mx % 32);
      check({tag, "_u3_max"}, int'(max3), mx % 8);
      begin
         bit o5 = 1'b0;
         bit o3 = 1'b0;
         for (int i = 1; i < 16; i++) begin
            if (hist[i] > 31) o5 = 1'b1;
            if (hist[i] > 7) o3 = 1'b1;
         end
         check({tag, "_u5_err"}, int'(err5), int'(o5));
         check({tag, "_u3_err"}, int'(err3), int'(o3));
      end
      check({tag, "_u5_end"}, int'(end5), 1);
      check({tag, "_u3_end"}, int'(end3), 1);
      check({tag, "_busy"}, int'(busy5), 0);
   endtask

   // Plays lens_a up to n_acc accepts; optional idle gaps and ignored start pulses.
   task automatic play(input string tag, input int gap_pct, input bit noise, input bit chk_end);
      int acc = 0;
      int guard = 0;
      bit rdy;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      check({tag, "_clr_end"}, int'(end5), 0);
      check({tag, "_clr_busy"}, int'(busy5), 1);
      check({tag, "_clr_cnt"}, sum5() + sum3(), 0);
      check({tag, "_clr_max_err"}, int'(max5) + int'(err5) + int'(err3), 0);
      while (acc < n_acc && guard < 500) begin
         guard++;
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            len_valid = 1'b0;
            len_in    = 4'($urandom);
            if (noise && rdy5 && ($urandom_range(2) == 0)) start = 1'b1;
         end else begin
            len_valid = 1'b1;
            len_in    = 4'(lens_a[acc]);
            len_last  = (acc == last_at);
         end
         rdy = rdy5;
         @(posedge clock);
         if (len_valid && rdy) acc++;
         @(negedge clock);
         start = 1'b0;
      end
      if (guard >= 500) check({tag, "_timeout"}, acc, n_acc);
      len_valid = 1'b0;
      len_last  = 1'b0;
      if (chk_end) begin
         check({tag, "_end_lat"}, int'(end5), 1);
         check({tag, "_done_rdy"}, int'(rdy5) + int'(rdy3), 0);
         // DONE must ignore further valid lengths.
         len_valid = 1'b1;
         len_in    = 4'd1;
         len_last  = 1'b1;
         repeat (2) @(negedge clock);
         len_valid = 1'b0;
         len_last  = 1'b0;
      end
   endtask

   task automatic fill_const(input int n, input int v);
      for (int k = 0; k < 32; k++) lens_a[k] = (k < n) ? v : 0;
   endtask

   initial begin
      #2;
      check("rst_busy", int'(busy5) + int'(busy3), 0);
      check("rst_rdy", int'(rdy5) + int'(rdy3), 0);
      check("rst_end", int'(end5) + int'(end3), 0);
      check("rst_cnt", sum5() + sum3() + int'(max5) + int'(err5), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_busy", int'(busy5), 0);

      // Directed table {3,3,3,3,3,2,4,4}.
      fill_const(8, 3);
      lens_a[5] = 2; lens_a[6] = 4; lens_a[7] = 4;
      last_at = 7; n_acc = 8;
      play("t8", 0, 1'b0, 1'b1);
      compare_all("t8");
      check("t8_c3", int'(c5[3]), 5);
      check("t8_max", int'(max5), 4);

      // 19 unused symbols, no len_last.
      fill_const(25, 0);
      last_at = -1; n_acc = NSYM;
      play("z19", 0, 1'b0, 1'b1);
      compare_all("z19");

      // Nine lengths of 5 saturate the narrow instance.
      fill_const(9, 5);
      last_at = 8; n_acc = 9;
      play("sat", 0, 1'b0, 1'b1);
      compare_all("sat");
      check("sat_u3_c5", int'(c3[5]), 7);
      check("sat_u3_err", int'(err3), 1);

      // Reset in the middle of a table, then a full table.
      for (int k = 0; k < 32; k++) lens_a[k] = k + 1;
      last_at = 5; n_acc = 3;
      play("prt", 0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      check("mid_rst_end", int'(end5), 0);
      check("mid_rst_busy", int'(busy5) + int'(rdy5), 0);
      check("mid_rst_cnt", sum5() + int'(max5), 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("post_rst_idle", int'(busy5) + int'(rdy5) + int'(end5), 0);
      for (int k = 0; k < 32; k++) lens_a[k] = (k % 4) + 7;
      n_acc = 6;
      play("rst2", 0, 1'b0, 1'b1);
      compare_all("rst2");

      // Random tables with stalls and ignored start pulses.
      for (int t = 0; t < 30; t++) begin
         for (int k = 0; k < 32; k++)
            lens_a[k] = ($urandom_range(1) == 0) ? int'($urandom_range(15)) : int'($urandom_range(3));
         last_at = int'($urandom_range(24));
         if (last_at >= NSYM) begin
            last_at = -1;
            n_acc = NSYM;
         end else begin
            n_acc = last_at + 1;
         end
         play($sformatf("r%0d", t), (t % 3 == 0) ? 0 : 40, 1'b1, 1'b1);
         compare_all($sformatf("r%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
